// File: rtl/imem_access_pkg.sv
// imem_access_pkg
// Shared types and sizes for the instruction-memory access controller.
//   state_t  : controller FSM states (IDLE / ACCESS / RESP)
//   req_id_t : requester identity (REQ_FETCH / REQ_DBG)
//   IMEM_*   : default memory geometry (128 x 32, 8-bit word address)
package imem_access_pkg;

  localparam int IMEM_DEPTH  = 128;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DBG   = 1'b1
  } req_id_t;

endpackage

// File: rtl/imem_arb_pick.sv
// imem_arb_pick
// Combinational winner selection between the fetch and debug requesters.
// Build option: IMEM_ARB_RR_EN selects round-robin (1-bit last-winner pointer);
// without it the policy is fixed priority, fetch over debug.
// Ports:
//   fetch_req, dbg_req : pending requests
//   last_id            : last granted requester (round-robin build only)
//   valid              : at least one request pending
//   win_id             : winner, 0 = fetch, 1 = debug (req_id_t encoding)
module imem_arb_pick
  import imem_access_pkg::*;
(
  input  logic fetch_req,
  input  logic dbg_req,
`ifdef IMEM_ARB_RR_EN
  input  logic last_id,
`endif
  output logic valid,
  output logic win_id
);

  always_comb begin
    valid  = fetch_req | dbg_req;
    win_id = REQ_FETCH;
`ifdef IMEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first.
    if (fetch_req && dbg_req) begin
      win_id = (last_id == REQ_FETCH) ? REQ_DBG : REQ_FETCH;
    end else if (dbg_req) begin
      win_id = REQ_DBG;
    end
`else
    if (!fetch_req && dbg_req) begin
      win_id = REQ_DBG;
    end
`endif
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl
// Arbitrates the single combinational read port of the instruction memory
// between instruction fetch and the debug/trace read port. Each access runs
// IDLE/RESP (arbitrate + latch) -> ACCESS (grant + read) -> RESP (response).
// Build option: IMEM_ARB_RR_EN enables round-robin arbitration (see
// imem_arb_pick); default is fixed priority, fetch first.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   fetch_req/addr/gnt/rvalid/rdata/rerr : fetch requester handshake
//   dbg_req/addr/gnt/rvalid/rdata/rerr   : debug requester handshake
//   mem_read, mem_addr, mem_rdata : memory read port (combinational read)
//
// state  | meaning
// IDLE   | no access in flight; latch a winner if anyone requests
// ACCESS | grant to cur_id, memory read of cur_addr, capture data at edge
// RESP   | rvalid to cur_id; latch the next winner or return to IDLE
module imem_access_ctrl
  import imem_access_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_rerr,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rerr,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One extra bit so DEPTH itself (e.g. 256 for an 8-bit address) is representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic              latch;
  logic [ADDR_W-1:0] cur_addr;
  req_id_t           cur_id;
  logic              in_range;
  logic              pick_valid;
  logic              pick_id;

`ifdef IMEM_ARB_RR_EN
  req_id_t last_id;
`endif

  imem_arb_pick u_pick (
    .fetch_req (fetch_req),
    .dbg_req   (dbg_req),
`ifdef IMEM_ARB_RR_EN
    .last_id   (last_id),
`endif
    .valid     (pick_valid),
    .win_id    (pick_id)
  );

  assign in_range = ({1'b0, cur_addr} < DEPTH_LIM);

  // cur_addr only changes at a latch, so it already holds its last value
  // outside ACCESS and resets to 0.
  assign mem_addr = cur_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          latch     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (pick_valid) begin
          latch     = 1'b1;
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    fetch_gnt    = 1'b0;
    dbg_gnt      = 1'b0;
    fetch_rvalid = 1'b0;
    dbg_rvalid   = 1'b0;
    mem_read     = 1'b0;
    case (state)
      ACCESS: begin
        fetch_gnt = (cur_id == REQ_FETCH);
        dbg_gnt   = (cur_id == REQ_DBG);
        mem_read  = in_range;
      end
      RESP: begin
        fetch_rvalid = (cur_id == REQ_FETCH);
        dbg_rvalid   = (cur_id == REQ_DBG);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr    <= '0;
      cur_id      <= REQ_FETCH;
      fetch_rdata <= '0;
      fetch_rerr  <= 1'b0;
      dbg_rdata   <= '0;
      dbg_rerr    <= 1'b0;
`ifdef IMEM_ARB_RR_EN
      // "Debug won last" makes fetch the preferred requester after reset.
      last_id     <= REQ_DBG;
`endif
    end else begin
      if (latch) begin
        cur_addr <= (pick_id == REQ_FETCH) ? fetch_addr : dbg_addr;
        cur_id   <= req_id_t'(pick_id);
`ifdef IMEM_ARB_RR_EN
        last_id  <= req_id_t'(pick_id);
`endif
      end
      if (state == ACCESS) begin
        if (cur_id == REQ_FETCH) begin
          fetch_rdata <= in_range ? mem_rdata : '0;
          fetch_rerr  <= ~in_range;
        end else begin
          dbg_rdata <= in_range ? mem_rdata : '0;
          dbg_rerr  <= ~in_range;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
module tb_imem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        fetch_rerr;
  logic        dbg_req;
  logic [7:0]  dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_rerr;
  logic        mem_read;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] mem [128];

  int total;
  int bad;

  imem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_rerr   (fetch_rerr),
    .dbg_req      (dbg_req),
    .dbg_addr     (dbg_addr),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_rdata    (dbg_rdata),
    .dbg_rerr     (dbg_rerr),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads return a marker so a leak into rdata is visible.
  always_comb begin
    if (mem_addr < 8'd128) mem_rdata = mem[mem_addr[6:0]];
    else                   mem_rdata = 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_f;
    logic exp_d;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    mem[1] = 32'h200D_0003;
    mem[2] = 32'hAE0D_0000;
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 8'd0;
    dbg_req    = 1'b0;
    dbg_addr   = 8'd0;
    cyc();
    cyc();
    rst = 1'b0;

    // reset state
    chk("rst_fetch_gnt", {31'd0, fetch_gnt}, 32'd0);
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, fetch_rvalid, dbg_rvalid}, 32'd0);
    chk("rst_rerr", {30'd0, fetch_rerr, dbg_rerr}, 32'd0);
    chk("rst_fetch_rdata", fetch_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);

    // single fetch, addr 2
    fetch_req = 1'b1; fetch_addr = 8'd2;
    cyc();
    chk("t1_c1_fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
    chk("t1_c1_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("t1_c1_mem_read", {31'd0, mem_read}, 32'd1);
    chk("t1_c1_mem_addr", {24'd0, mem_addr}, 32'd2);
    chk("t1_c1_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    fetch_req = 1'b0;
    cyc();
    chk("t1_c2_rvalid", {31'd0, fetch_rvalid}, 32'd1);
    chk("t1_c2_rdata", fetch_rdata, 32'hAE0D_0000);
    chk("t1_c2_rerr", {31'd0, fetch_rerr}, 32'd0);
    chk("t1_c2_mem_read", {31'd0, mem_read}, 32'd0);
    chk("t1_c2_gnt", {31'd0, fetch_gnt}, 32'd0);
    cyc();
    chk("t1_c3_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("t1_c3_rdata_hold", fetch_rdata, 32'hAE0D_0000);
    chk("t1_c3_mem_addr_hold", {24'd0, mem_addr}, 32'd2);

    // simultaneous fetch addr 1 / dbg addr 2 from a fresh reset
    do_reset();
    fetch_req = 1'b1; fetch_addr = 8'd1;
    dbg_req   = 1'b1; dbg_addr   = 8'd2;
    cyc();
    chk("t2_c1_fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
    chk("t2_c1_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    fetch_req = 1'b0;
    cyc();
    chk("t2_c2_fetch_rvalid", {31'd0, fetch_rvalid}, 32'd1);
    chk("t2_c2_fetch_rdata", fetch_rdata, 32'h200D_0003);
    chk("t2_c2_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    cyc();
    chk("t2_c3_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("t2_c3_mem_addr", {24'd0, mem_addr}, 32'd2);
    chk("t2_c3_fetch_gnt", {31'd0, fetch_gnt}, 32'd0);
    dbg_req = 1'b0;
    cyc();
    chk("t2_c4_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("t2_c4_dbg_rdata", dbg_rdata, 32'hAE0D_0000);
    chk("t2_c4_dbg_rerr", {31'd0, dbg_rerr}, 32'd0);
    chk("t2_c4_fetch_rdata_hold", fetch_rdata, 32'h200D_0003);
    cyc();

    // continuous requests from both after reset
    do_reset();
    fetch_req = 1'b1; fetch_addr = 8'd1;
    dbg_req   = 1'b1; dbg_addr   = 8'd2;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k % 2 == 1) begin
`ifdef IMEM_ARB_RR_EN
        exp_f = (k % 4 == 1);
`else
        exp_f = 1'b1;
`endif
        exp_d = ~exp_f;
      end else begin
        exp_f = 1'b0;
        exp_d = 1'b0;
      end
      chk($sformatf("t3_c%0d_fetch_gnt", k), {31'd0, fetch_gnt}, {31'd0, exp_f});
      chk($sformatf("t3_c%0d_dbg_gnt", k), {31'd0, dbg_gnt}, {31'd0, exp_d});
    end
    fetch_req = 1'b0;
    dbg_req   = 1'b0;
    cyc();
    cyc();

    // out-of-range debug read
    dbg_req = 1'b1; dbg_addr = 8'd200;
    cyc();
    chk("t4_c1_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("t4_c1_mem_read", {31'd0, mem_read}, 32'd0);
    chk("t4_c1_mem_addr", {24'd0, mem_addr}, 32'd200);
    dbg_req = 1'b0;
    cyc();
    chk("t4_c2_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("t4_c2_dbg_rdata", dbg_rdata, 32'd0);
    chk("t4_c2_dbg_rerr", {31'd0, dbg_rerr}, 32'd1);
    chk("t4_c2_mem_read", {31'd0, mem_read}, 32'd0);
    cyc();

    // reset during the ACCESS cycle of a fetch
    fetch_req = 1'b1; fetch_addr = 8'd1;
    cyc();
    chk("t5_c1_fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
    rst = 1'b1; fetch_req = 1'b0;
    cyc();
    rst = 1'b0;
    chk("t5_c2_fetch_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("t5_c2_gnt", {30'd0, fetch_gnt, dbg_gnt}, 32'd0);
    chk("t5_c2_mem_read", {31'd0, mem_read}, 32'd0);
    chk("t5_c2_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("t5_c2_fetch_rdata", fetch_rdata, 32'd0);
    chk("t5_c2_rerr", {30'd0, fetch_rerr, dbg_rerr}, 32'd0);
    chk("t5_c2_dbg_rdata", dbg_rdata, 32'd0);
    cyc();
    chk("t5_c3_fetch_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    fetch_req = 1'b1; fetch_addr = 8'd2;
    cyc();
    chk("t5_new_gnt", {31'd0, fetch_gnt}, 32'd1);
    fetch_req = 1'b0;
    cyc();
    chk("t5_new_rvalid", {31'd0, fetch_rvalid}, 32'd1);
    chk("t5_new_rdata", fetch_rdata, 32'hAE0D_0000);
    cyc();

    // back-to-back fetches, addr 1 then 2
    fetch_req = 1'b1; fetch_addr = 8'd1;
    cyc();
    chk("t6_c1_gnt", {31'd0, fetch_gnt}, 32'd1);
    fetch_addr = 8'd2;
    cyc();
    chk("t6_c2_rvalid", {31'd0, fetch_rvalid}, 32'd1);
    chk("t6_c2_rdata", fetch_rdata, 32'h200D_0003);
    cyc();
    chk("t6_c3_gnt", {31'd0, fetch_gnt}, 32'd1);
    chk("t6_c3_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("t6_c3_rdata_hold", fetch_rdata, 32'h200D_0003);
    chk("t6_c3_mem_addr", {24'd0, mem_addr}, 32'd2);
    fetch_req = 1'b0;
    cyc();
    chk("t6_c4_rvalid", {31'd0, fetch_rvalid}, 32'd1);
    chk("t6_c4_rdata", fetch_rdata, 32'hAE0D_0000);
    cyc();
    chk("t6_c5_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("t6_c5_gnt", {31'd0, fetch_gnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
